alu_op_sequencer: RTL and testbench

//   Upstream issue stage for the 4-bit ALU/compare unit (opc[2:0], a[3:0], b[3:0] -> c[7:0]).

---
 rtl/alu_op_sequencer_if.sv | 40 ++++
 rtl/alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: producer, consumer and ALU-side signals of the ALU
// issue sequencer, grouped so the sequencer and its environment connect
// through a single port.
//   slave  - the sequencer's view
//   master - the environment's view (producer, consumer and ALU model)
interface alu_op_sequencer_if #(
  parameter int TAG_W = 4
);
  // producer side
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_opc;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  // ALU side
  logic [2:0]       alu_opc;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [7:0]       alu_c;
  // consumer side
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_res;
  logic [TAG_W-1:0] out_tag;
  logic             out_cmp;
  logic             busy;

  modport slave (
    input  in_valid, in_opc, in_a, in_b, in_tag, alu_c, out_ready,
    output in_ready, alu_opc, alu_a, alu_b, out_valid, out_res, out_tag,
           out_cmp, busy
  );

  modport master (
    output in_valid, in_opc, in_a, in_b, in_tag, alu_c, out_ready,
    input  in_ready, alu_opc, alu_a, alu_b, out_valid, out_res, out_tag,
           out_cmp, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of the 4-bit ALU/compare unit.
// Tagged ops are queued in a DEPTH-entry FIFO, issued one at a time on the
// registered alu_* outputs, and after ALU_LAT cycles the ALU result is
// captured and presented with its tag on the consumer handshake.
// Optional feature: define ALU_SEQ_STATS_EN to add the stat_ops/stat_true
// consumed-result counters.
module alu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_true
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 4 + 4 + TAG_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [2:0]    LAT_LOAD = 3'(ALU_LAT);

  // FIFO storage and bookkeeping
  logic [EW-1:0]    fifo_mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;

  // issue/capture state
  logic [1:0]       state_r;
  logic [2:0]       cnt_r;
  logic [TAG_W-1:0] tag_sh_r;
  logic             cmp_sh_r;

  // registered outputs
  logic [2:0]       alu_opc_r;
  logic [3:0]       alu_a_r;
  logic [3:0]       alu_b_r;
  logic             out_valid_r;
  logic [7:0]       out_res_r;
  logic [TAG_W-1:0] out_tag_r;
  logic             out_cmp_r;

  logic             full_s;
  logic             empty_s;
  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic [EW-1:0]    head_s;
  logic [2:0]       head_opc_s;
  logic [3:0]       head_a_s;
  logic [3:0]       head_b_s;
  logic [TAG_W-1:0] head_tag_s;

  assign full_s     = (count_r == CNT_FULL);
  assign empty_s    = (count_r == CNT_ZERO);
  // No bypass: a full FIFO refuses input even if it pops this cycle.
  assign in_ready_s = rst_n && !full_s;
  assign push_s     = bus.in_valid && in_ready_s;
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign {head_opc_s, head_a_s, head_b_s, head_tag_s} = head_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.alu_opc   = alu_opc_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_res   = out_res_r;
  assign bus.out_tag   = out_tag_r;
  assign bus.out_cmp   = out_cmp_r;
  assign bus.busy      = (state_r != ST_IDLE) || !empty_s;

  // Decide whether the FIFO head is issued this cycle.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready && !empty_s) begin
          pop_s = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO entry write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {bus.in_opc, bus.in_a, bus.in_b, bus.in_tag};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue FSM: load the ALU operands, count out the ALU latency, capture and hold the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      tag_sh_r    <= {TAG_W{1'b0}};
      cmp_sh_r    <= 1'b0;
      alu_opc_r   <= 3'd0;
      alu_a_r     <= 4'd0;
      alu_b_r     <= 4'd0;
      out_valid_r <= 1'b0;
      out_res_r   <= 8'd0;
      out_tag_r   <= {TAG_W{1'b0}};
      out_cmp_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            alu_opc_r <= head_opc_s;
            alu_a_r   <= head_a_s;
            alu_b_r   <= head_b_s;
            tag_sh_r  <= head_tag_s;
            cmp_sh_r  <= (head_opc_s >= 3'd3);
            cnt_r     <= LAT_LOAD;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The cnt==0 cycle is the capture cycle, so WAIT spans ALU_LAT+1 cycles.
          if (cnt_r == 3'd0) begin
            out_res_r   <= bus.alu_c;
            out_tag_r   <= tag_sh_r;
            out_cmp_r   <= cmp_sh_r;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (pop_s) begin
              alu_opc_r <= head_opc_s;
              alu_a_r   <= head_a_s;
              alu_b_r   <= head_b_s;
              tag_sh_r  <= head_tag_s;
              cmp_sh_r  <= (head_opc_s >= 3'd3);
              cnt_r     <= LAT_LOAD;
              state_r   <= ST_WAIT;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_r;
  logic [15:0] stat_true_r;

  assign stat_ops  = stat_ops_r;
  assign stat_true = stat_true_r;

  // Saturating counters of consumed results and of consumed true compares.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops_r  <= 16'd0;
      stat_true_r <= 16'd0;
    end else if (out_valid_r && bus.out_ready) begin
      if (stat_ops_r != 16'hFFFF) begin
        stat_ops_r <= stat_ops_r + 16'd1;
      end
      if (out_cmp_r && (out_res_r != 8'h00) && (stat_true_r != 16'hFFFF)) begin
        stat_true_r <= stat_true_r + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for alu_op_sequencer with a
// registered 1-cycle ALU model. Expected results are queued on acceptance
// and compared when results are consumed.
module tb_alu_op_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer_if #(.TAG_W(4)) ifc ();

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_true;
`endif

  alu_op_sequencer #(.DEPTH(4), .ALU_LAT(1), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_true (stat_true)
`endif
  );

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] tag;
    logic       cmp;
  } exp_t;

  exp_t sb[$];
  exp_t head_e;
  int   out_cyc[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [7:0] alu_model(input logic [2:0] opc,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'd0, a};
    eb = {4'd0, b};
    case (opc)
      3'd0:    return ea + eb;
      3'd1:    return ea - eb;
      3'd2:    return ea * eb;
      3'd3:    return {7'd0, (a <  b)};
      3'd4:    return {7'd0, (a >  b)};
      3'd5:    return {7'd0, (a == b)};
      3'd6:    return {7'd0, (a <= b)};
      default: return {7'd0, (a >= b)};
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [2:0] opc, input logic [3:0] a,
                                  input logic [3:0] b, input logic [3:0] tag);
    exp_t e;
    e.res = alu_model(opc, a, b);
    e.tag = tag;
    e.cmp = (opc >= 3'd3);
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU model: registered, one cycle from alu_* to alu_c
  always @(posedge clk) ifc.alu_c <= alu_model(ifc.alu_opc, ifc.alu_a, ifc.alu_b);

  // edge counter: after the k-th rising edge cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: queue on acceptance, compare on consumption
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (ifc.in_valid && ifc.in_ready)
        sb.push_back(mk_exp(ifc.in_opc, ifc.in_a, ifc.in_b, ifc.in_tag));
      if (ifc.out_valid && ifc.out_ready) begin
        check_eq("out_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          head_e = sb.pop_front();
          check_eq("out_res", ifc.out_res, head_e.res);
          check_eq("out_tag", ifc.out_tag, head_e.tag);
          check_eq("out_cmp", ifc.out_cmp, head_e.cmp);
        end
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op; returns the edge index at which it was accepted.
  task automatic send(input logic [2:0] opc, input logic [3:0] a,
                      input logic [3:0] b, input logic [3:0] tag,
                      output int acc);
    int n;
    ifc.in_valid = 1'b1;
    ifc.in_opc   = opc;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_tag   = tag;
    n = 0;
    while (!ifc.in_ready && n < 60) begin
      tick();
      n++;
    end
    if (!ifc.in_ready) check_eq("send_timeout", 0, 1);
    tick();
    acc = cyc;
  endtask

  task automatic idle_in();
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ifc.out_valid) && n < 300) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int seen;
    ifc.in_valid  = 1'b1;
    ifc.in_opc    = 3'd0;
    ifc.in_a      = 4'd0;
    ifc.in_b      = 4'd0;
    ifc.in_tag    = 4'd0;
    ifc.out_ready = 1'b0;
    rst_n         = 1'b0;

    // reset with in_valid asserted
    tick();
    tick();
    check_eq("rst_in_ready", ifc.in_ready, 0);
    check_eq("rst_out_valid", ifc.out_valid, 0);
    check_eq("rst_alu_opc", ifc.alu_opc, 0);
    check_eq("rst_alu_a", ifc.alu_a, 0);
    check_eq("rst_alu_b", ifc.alu_b, 0);
    check_eq("rst_busy", ifc.busy, 0);
    idle_in();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("post_rst_busy", ifc.busy, 0);
    check_eq("post_rst_valid", ifc.out_valid, 0);
    check_eq("post_rst_ready", ifc.in_ready, 1);

    // single op: out_valid three edges after the accepting edge (cycle N+4)
    ifc.out_ready = 1'b1;
    out_cyc.delete();
    send(3'd0, 4'd1, 4'd1, 4'd3, acc);
    idle_in();
    drain();
    check_eq("single_count", out_cyc.size(), 1);
    if (out_cyc.size() != 0) check_eq("single_lat", out_cyc[0] - acc, 3);

    // subtract wrap and multiply
    out_cyc.delete();
    send(3'd1, 4'd0, 4'd1, 4'd5, acc);
    idle_in();
    drain();
    if (out_cyc.size() != 0) check_eq("wrap_lat", out_cyc[0] - acc, 3);
    send(3'd2, 4'd15, 4'd15, 4'd6, acc);
    idle_in();
    drain();

    // sweep all opcodes from a fresh reset, back-to-back
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_cyc.delete();
    for (int i = 0; i < 8; i++) send(3'(i), 4'd1, 4'd0, 4'(i), acc);
    idle_in();
    drain();
    check_eq("sweep_count", out_cyc.size(), 8);
    for (int i = 1; i < out_cyc.size(); i++)
      check_eq("sweep_gap", out_cyc[i] - out_cyc[i-1], 3);
`ifdef ALU_SEQ_STATS_EN
    check_eq("stat_ops", stat_ops, 8);
    check_eq("stat_true", stat_true, 2);
`endif

    // backpressure: 1 in HOLD + 4 in FIFO, sixth refused
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(3'(i), 4'(i + 2), 4'd3, 4'(8 + i), acc);
    ifc.in_valid = 1'b1;
    ifc.in_tag   = 4'd13;
    repeat (6) tick();
    check_eq("bp_in_ready", ifc.in_ready, 0);
    check_eq("bp_queued", sb.size(), 5);
    check_eq("bp_out_valid", ifc.out_valid, 1);
    check_eq("bp_busy", ifc.busy, 1);
    idle_in();
    ifc.out_ready = 1'b1;
    drain();
    check_eq("bp_ready_after", ifc.in_ready, 1);

    // reset while the op is in WAIT
    send(3'd0, 4'd2, 4'd3, 4'd1, acc);
    idle_in();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ifc.out_valid) seen = 1;
      tick();
    end
    check_eq("rstw_no_valid", seen, 0);
    check_eq("rstw_busy", ifc.busy, 0);
    check_eq("rstw_sb_empty", sb.size(), 0);
    out_cyc.delete();
    send(3'd0, 4'd1, 4'd1, 4'd3, acc);
    idle_in();
    drain();
    check_eq("rstw_count", out_cyc.size(), 1);
    if (out_cyc.size() != 0) check_eq("rstw_lat", out_cyc[0] - acc, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
